// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keypad_pkg
// Brief    : Shared types and width helper for the keypad matrix scanner.
// Revision : 1.0 - initial release
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_class_t;

    // Ceiling log2, floored at 1 so derived vectors never collapse to zero width.
    function automatic int clog2_min1(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_col_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_col_scanner
// Brief    : Column drive rotation, row synchroniser and per-frame snapshot.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_col_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int SCAN_DIV = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   scan_en,
    input  logic [ROWS-1:0]        row_in,
    output logic [COLS-1:0]        col_drv,
    output logic [ROWS*COLS-1:0]   snapshot,
    output logic                   frame_end
);

    localparam int DIV_W = clog2_min1(SCAN_DIV);
    localparam int COL_W = clog2_min1(COLS);
    localparam logic [DIV_W-1:0] DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);

    logic             running;
    logic [DIV_W-1:0] dwell;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_next;
    logic             dwell_done;
    logic [ROWS-1:0]  row_meta;
    logic [ROWS-1:0]  row_sync;

    assign dwell_done = running && (dwell == DWELL_LAST);
    assign col_next   = (col == COL_LAST) ? '0 : col + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta <= '0;
            row_sync <= '0;
        end else begin
            row_meta <= row_in;
            row_sync <= row_meta;
        end
    end

    // 'running' lets the first enabled clock load col 0 so its dwell is full length.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running   <= 1'b1;
            dwell     <= '0;
            col       <= '0;
            col_drv   <= COLS'(1);
            frame_end <= 1'b0;
            snapshot  <= '0;
        end else if (!scan_en) begin
            running   <= 1'b0;
            dwell     <= '0;
            col       <= '0;
            col_drv   <= '0;
            frame_end <= 1'b0;
            snapshot  <= '0;
        end else if (!running) begin
            running   <= 1'b1;
            col_drv   <= COLS'(1);
            frame_end <= 1'b0;
        end else begin
            // Pulses once the last column has landed, so the snapshot is whole.
            frame_end <= dwell_done && (col == COL_LAST);
            if (dwell_done) begin
                dwell   <= '0;
                col     <= col_next;
                col_drv <= COLS'(1) << col_next;
                for (int c = 0; c < COLS; c++) begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (col == COL_W'(c)) begin
                            snapshot[r*COLS + c] <= row_sync[r];
                        end
                    end
                end
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Brief    : Scanned ROWS x COLS keypad with debounce, release and repeat.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DIV        = 16,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int REPEAT_FRAMES   = 0,
    localparam int KW             = clog2_min1(ROWS * COLS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            scan_en,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_drv,
    output logic [KW-1:0]   key_code,
    output logic            key_valid,
    output logic            key_release,
    output logic            key_held,
    output logic            multi_key
);

    localparam int NKEYS = ROWS * COLS;
    localparam int CNT_W = clog2_min1(DEBOUNCE_FRAMES + 1);
    localparam int REP_W = clog2_min1(REPEAT_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);
    localparam logic [REP_W-1:0] REP_LAST =
        REP_W'((REPEAT_FRAMES == 0) ? 0 : REPEAT_FRAMES - 1);

    logic [NKEYS-1:0] snapshot;
    logic             frame_end;
    logic [1:0]       n_closed;
    logic [KW-1:0]    hit_idx;
    frame_class_t     fclass;
    state_t           state;
    logic [KW-1:0]    cand;
    logic [CNT_W-1:0] cnt;
    logic [REP_W-1:0] rep;
    logic             cand_hit;

    keypad_col_scanner #(
        .ROWS     (ROWS),
        .COLS     (COLS),
        .SCAN_DIV (SCAN_DIV)
    ) u_col_scanner (
        .clk       (clk),
        .rst       (rst),
        .scan_en   (scan_en),
        .row_in    (row_in),
        .col_drv   (col_drv),
        .snapshot  (snapshot),
        .frame_end (frame_end)
    );

    // Saturating count of closed keys; hit_idx is only meaningful for SINGLE.
    always_comb begin
        n_closed = 2'd0;
        hit_idx  = '0;
        for (int k = 0; k < NKEYS; k++) begin
            if (snapshot[k]) begin
                if (n_closed != 2'd2) begin
                    n_closed = n_closed + 2'd1;
                end
                hit_idx = KW'(k);
            end
        end
        case (n_closed)
            2'd0:    fclass = NONE;
            2'd1:    fclass = SINGLE;
            default: fclass = MULTI;
        endcase
    end

    assign cand_hit = snapshot[cand];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cand        <= '0;
            cnt         <= '0;
            rep         <= '0;
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            key_held    <= 1'b0;
            multi_key   <= 1'b0;
        end else begin
            key_valid   <= 1'b0;
            key_release <= 1'b0;
            if (!scan_en) begin
                if (state == HELD || state == REL_DB) begin
                    key_release <= 1'b1;
                end
                state     <= IDLE;
                key_held  <= 1'b0;
                multi_key <= 1'b0;
                cnt       <= '0;
                rep       <= '0;
            end else if (frame_end) begin
                multi_key <= (fclass == MULTI);
                case (state)
                    IDLE: begin
                        if (fclass == SINGLE) begin
                            cand <= hit_idx;
                            if (DEBOUNCE_FRAMES == 1) begin
                                state     <= HELD;
                                key_code  <= hit_idx;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rep       <= '0;
                                cnt       <= '0;
                            end else begin
                                state <= PRESS_DB;
                                cnt   <= CNT_ONE;
                            end
                        end
                    end
                    PRESS_DB: begin
                        if (fclass == SINGLE && hit_idx == cand) begin
                            if (cnt == CNT_LAST) begin
                                state     <= HELD;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                rep       <= '0;
                                cnt       <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    HELD: begin
                        // Rollover: extra keys are ignored while the candidate stays closed.
                        if (cand_hit) begin
                            if (REPEAT_FRAMES != 0) begin
                                if (rep == REP_LAST) begin
                                    key_valid <= 1'b1;
                                    rep       <= '0;
                                end else begin
                                    rep <= rep + 1'b1;
                                end
                            end
                        end else if (DEBOUNCE_FRAMES == 1) begin
                            state       <= IDLE;
                            key_held    <= 1'b0;
                            key_release <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            state <= REL_DB;
                            cnt   <= CNT_ONE;
                        end
                    end
                    REL_DB: begin
                        if (cand_hit) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == CNT_LAST) begin
                            state       <= IDLE;
                            key_held    <= 1'b0;
                            key_release <= 1'b1;
                            cnt         <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scanner
// Brief    : Directed bench for keypad_scanner, two instances (no repeat / repeat 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

    localparam int ROWS     = 4;
    localparam int COLS     = 4;
    localparam int SCAN_DIV = 4;
    localparam int DB       = 3;
    localparam int FRAME    = COLS * SCAN_DIV;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        scan_en = 1'b1;
    logic [15:0] keys    = '0;

    always #5 clk = ~clk;

    logic [3:0] col0, col1, row0, row1, code0, code1;
    logic       v0, v1, r0, r1, h0, h1, m0, m1;

    // Ideal switch matrix: a row returns high when a closed key sits on the driven column.
    always_comb begin
        row0 = '0;
        row1 = '0;
        for (int r = 0; r < ROWS; r++) begin
            row0[r] = |(keys[r*COLS +: COLS] & col0);
            row1[r] = |(keys[r*COLS +: COLS] & col1);
        end
    end

    keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                     .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(0)) dut0 (
        .clk(clk), .rst(rst), .scan_en(scan_en), .row_in(row0), .col_drv(col0),
        .key_code(code0), .key_valid(v0), .key_release(r0), .key_held(h0), .multi_key(m0));

    keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV),
                     .DEBOUNCE_FRAMES(DB), .REPEAT_FRAMES(2)) dut1 (
        .clk(clk), .rst(rst), .scan_en(scan_en), .row_in(row1), .col_drv(col1),
        .key_code(code1), .key_valid(v1), .key_release(r1), .key_held(h1), .multi_key(m1));

    // ---------------- behavioural model (frame-level) ----------------
    typedef struct {
        bit         held;
        int         streak;
        int         rel;
        int         rep;
        logic [3:0] cand;
        logic [3:0] code;
        bit         valid;
        bit         rls;
        bit         multi;
    } mdl_t;

    mdl_t        ms0, ms1;
    bit          run  = 1'b1;
    int          pos  = 0;
    bit          pend = 1'b0;
    logic [15:0] snap = '0;
    logic [3:0]  e_col = 4'b0001;

    int vectors     = 0;
    int miscompares = 0;
    int vcnt0 = 0, vcnt1 = 0, rcnt0 = 0;

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.held = 0; s.streak = 0; s.rel = 0; s.rep = 0; s.cand = '0;
        s.code = '0; s.valid = 0; s.rls = 0; s.multi = 0;
        return s;
    endfunction

    function automatic mdl_t mdl_disable(mdl_t s);
        s.rls = s.held;
        s.held = 0; s.streak = 0; s.rel = 0; s.rep = 0; s.multi = 0;
        return s;
    endfunction

    function automatic mdl_t mdl_frame(mdl_t s, logic [15:0] f, int rep_frames);
        int n;
        n = $countones(f);
        s.multi = (n > 1);
        if (!s.held) begin
            if (s.streak > 0) begin
                s.streak = (n == 1 && f[s.cand]) ? s.streak + 1 : 0;
            end else if (n == 1) begin
                for (int k = 0; k < 16; k++) if (f[k]) s.cand = 4'(k);
                s.streak = 1;
            end
            if (s.streak == DB) begin
                s.held = 1; s.streak = 0; s.rep = 0; s.rel = 0;
                s.valid = 1; s.code = s.cand;
            end
        end else if (f[s.cand]) begin
            if (s.rel > 0) begin
                s.rel = 0;
            end else begin
                s.rep++;
                if (rep_frames != 0 && s.rep == rep_frames) begin
                    s.valid = 1; s.rep = 0;
                end
            end
        end else begin
            s.rel++;
            if (s.rel == DB) begin
                s.held = 0; s.rel = 0; s.rls = 1;
            end
        end
        return s;
    endfunction

    initial begin
        ms0 = mdl_reset();
        ms1 = mdl_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                run = 1; pos = 0; pend = 0; snap = '0; e_col = 4'b0001;
                ms0 = mdl_reset(); ms1 = mdl_reset();
            end else begin
                ms0.valid = 0; ms0.rls = 0; ms1.valid = 0; ms1.rls = 0;
                if (!scan_en) begin
                    ms0 = mdl_disable(ms0); ms1 = mdl_disable(ms1);
                    run = 0; pos = 0; pend = 0; e_col = '0;
                end else begin
                    if (pend) begin
                        ms0 = mdl_frame(ms0, snap, 0);
                        ms1 = mdl_frame(ms1, snap, 2);
                    end
                    pend = 0;
                    if (!run) begin
                        run = 1; pos = 0;
                    end else begin
                        pos = (pos + 1) % FRAME;
                        if (pos == 0) begin
                            pend = 1; snap = keys;
                        end
                    end
                    e_col = 4'(1 << (pos / SCAN_DIV));
                end
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_dut(input string nm, input logic [3:0] col, input logic [3:0] code,
                             input logic v, input logic r, input logic h, input logic m,
                             input mdl_t s);
        vectors++;
        if (col !== e_col || code !== s.code || v !== s.valid || r !== s.rls ||
            h !== s.held || m !== s.multi) begin
            miscompares++;
            $display("FAIL %s t=%0t got col=%b code=%0d valid=%b rel=%b held=%b multi=%b want col=%b code=%0d valid=%b rel=%b held=%b multi=%b",
                     nm, $time, col, code, v, r, h, m, e_col, s.code, s.valid, s.rls, s.held, s.multi);
        end
    endtask

    task automatic lit(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check_dut("dut0", col0, code0, v0, r0, h0, m0, ms0);
            check_dut("dut1", col1, code1, v1, r1, h1, m1, ms1);
            if (v0 === 1'b1) vcnt0++;
            if (v1 === 1'b1) vcnt1++;
            if (r0 === 1'b1) rcnt0++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic restart(input logic [15:0] k);
        rst = 1'b1; scan_en = 1'b1; keys = k;
        cycles(2);
        lit("reset_col", int'(col0), 1);
        lit("reset_outs", int'({code0, v0, r0, h0, m0}), 0);
        rst = 1'b0;
    endtask

    int b0, b1, br;

    initial begin
        // 1: reset and scan order
        restart(16'h0000);
        lit("scan_c0", int'(col0), 1);
        cycles(3);  lit("scan_c0_end", int'(col0), 1);
        cycles(1);  lit("scan_c1", int'(col0), 2);
        cycles(4);  lit("scan_c2", int'(col0), 4);
        cycles(4);  lit("scan_c3", int'(col0), 8);
        cycles(4);  lit("scan_wrap", int'(col0), 1);
        lit("idle_outs", int'({v0, h0, m0}), 0);

        // 2: clean press of key 9, then release
        restart(16'h0200);
        b0 = vcnt0;
        cycles(48); lit("press_early", int'(v0), 0);
        cycles(1);  lit("press_valid", int'(v0), 1);
                    lit("press_code", int'(code0), 9);
                    lit("press_held", int'(h0), 1);
        cycles(31); keys = 16'h0000;
        cycles(48); lit("rel_early", int'(r0), 0);
        cycles(1);  lit("rel_pulse", int'(r0), 1);
                    lit("rel_held", int'(h0), 0);
                    lit("rel_code", int'(code0), 9);
        lit("press_count", vcnt0 - b0, 1);

        // 3: bounce 2 on / 1 off / 3 on
        restart(16'h0200);
        b0 = vcnt0; br = rcnt0;
        cycles(32); keys = 16'h0000;
        cycles(16); keys = 16'h0200;
        cycles(48); lit("bounce_early", vcnt0 - b0, 0);
        cycles(1);  lit("bounce_valid", int'(v0), 1);
        cycles(40); lit("bounce_count", vcnt0 - b0, 1);
                    lit("bounce_norel", rcnt0 - br, 0);

        // 4: multi-key from idle, then rollover while holding key 5
        restart(16'h8001);
        b0 = vcnt0;
        cycles(17); lit("multi_flag", int'(m0), 1);
                    lit("multi_novalid", vcnt0 - b0, 0);
        cycles(15); keys = 16'h0020;
        cycles(49); lit("k5_valid", int'(v0), 1);
                    lit("k5_code", int'(code0), 5);
        cycles(15); keys = 16'h0060;
        cycles(24); lit("roll_held", int'(h0), 1);
                    lit("roll_code", int'(code0), 5);
                    lit("roll_multi", int'(m0), 1);

        // 5: typematic repeat every 2 frames on key 3
        restart(16'h0008);
        b0 = vcnt0; b1 = vcnt1;
        cycles(81);  lit("rep_pulse", int'(v1), 1);
                     lit("rep_code", int'(code1), 3);
        cycles(127); keys = 16'h0000;
        cycles(60);  lit("rep_count", vcnt1 - b1, 6);
                     lit("norep_count", vcnt0 - b0, 1);

        // 6: scan disable while held, then asynchronous reset mid-dwell
        restart(16'h0200);
        cycles(60); scan_en = 1'b0;
        cycles(1);  lit("dis_col", int'(col0), 0);
                    lit("dis_rel", int'(r0), 1);
                    lit("dis_held", int'(h0), 0);
        cycles(3);  lit("dis_rel_once", int'(r0), 0);
                    scan_en = 1'b1;
        cycles(1);  lit("en_col", int'(col0), 1);
        cycles(49); lit("reacq_valid", int'(v0), 1);
        #2 rst = 1'b1;
        #1 lit("arst_outs", int'({code0, v0, r0, h0, m0}), 0);
           lit("arst_col", int'(col0), 1);
        br = rcnt0;
        cycles(2); rst = 1'b0;
        cycles(5); lit("arst_norel", rcnt0 - br, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised successor to the team's 4x4 keypad decoder.
- Actively scans a ROWS x COLS switch matrix by driving one column at a time, then synchronises and debounces the row returns.
- Emits a row-major key code with press, release and optional typematic-repeat strobes.
- Sits between the board keypad pins and the microprocessor's input register / interrupt logic.

Parameters:
- ROWS, 4, number of row inputs (2..8).
- COLS, 4, number of column drive outputs (2..8).
- SCAN_DIV, 16, clocks each column is driven per dwell (min 4).
- DEBOUNCE_FRAMES, 3, consecutive frames required to accept a press or release (min 1).
- REPEAT_FRAMES, 0, frames between repeat strobes while held; 0 disables repeat.
- KW, clog2(ROWS*COLS), key code width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- scan_en  in  1  high = scanning active.
- row_in  in  ROWS  raw row returns, active-high, asynchronous to clk.
- col_drv  out  COLS  one-hot active-high column drive.
- key_code  out  KW  code of accepted key, = row*COLS + col.
- key_valid  out  1  1-cycle pulse on accepted press or repeat.
- key_release  out  1  1-cycle pulse on debounced release.
- key_held  out  1  high from accepted press until debounced release.
- multi_key  out  1  level: last frame had more than one key closed.

Behaviour:
- Reset values (asynchronous): col_drv = 1 (col 0), key_code = 0, key_valid = 0, key_release = 0, key_held = 0, multi_key = 0, FSM = IDLE, all counters 0. No pulses are generated by reset.
- Synchronisation: row_in passes through a 2-flop synchroniser.
- Row sampling: rows are sampled into the frame snapshot on the last clock of each dwell. SCAN_DIV >= 4 guarantees synchronised data reflects the current column.
- Column advance: col_drv rotates to the next column after SCAN_DIV clocks, wrapping from col COLS-1 to col 0.
- Frame end: asserted internally for one cycle on the last clock of the col COLS-1 dwell. The snapshot (ROWS*COLS bits) is evaluated there.
- Frame classification: NONE (0 bits set), SINGLE(idx) (exactly 1 bit set), MULTI (2 or more). multi_key updates at every frame end.
- IDLE:
  - SINGLE(i): go to PRESS_DB, cand = i, cnt = 1. If DEBOUNCE_FRAMES = 1, accept immediately (see acceptance).
  - NONE or MULTI: stay in IDLE.
- PRESS_DB:
  - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_FRAMES, accept.
  - Anything else: go to IDLE with no pulse.
- Acceptance: in the cycle after the qualifying frame end, key_code = cand, key_valid = 1 for 1 cycle, key_held = 1, state = HELD, rep = 0.
- HELD:
  - cand bit still set in the snapshot (other keys may also be set; rollover ignored): rep++. If REPEAT_FRAMES != 0 and rep reaches REPEAT_FRAMES, pulse key_valid (same key_code) and set rep = 0.
  - cand bit clear: go to REL_DB with cnt = 1. If DEBOUNCE_FRAMES = 1, release immediately.
- REL_DB:
  - cand bit clear: cnt++. When cnt reaches DEBOUNCE_FRAMES, release.
  - cand bit set: return to HELD; rep is not cleared.
- Release: in the cycle after the qualifying frame end, key_release = 1 for 1 cycle, key_held = 0, state = IDLE. key_code retains its last value.
- Latency: press latency is DEBOUNCE_FRAMES frames plus 1 clock from the first full frame containing the key. Frame = COLS*SCAN_DIV clocks.
- scan_en low (synchronous):
  - col_drv = 0; dwell and column counters reset so scanning restarts at col 0.
  - FSM forced to IDLE and key_held cleared. If the FSM was in HELD or REL_DB, key_release pulses once.
  - scan_en rising: the first frame starts at col 0.
- Counter saturation: cnt is sized clog2(DEBOUNCE_FRAMES+1) and rep is sized clog2(REPEAT_FRAMES+1); neither can overflow.
- Reset mid-scan: all state is cleared immediately, and scanning restarts at col 0 on the first clock after rst is released.

Decomposition:
- Package keypad_pkg holds:
  - state enum {IDLE, PRESS_DB, HELD, REL_DB};
  - frame class enum {NONE, SINGLE, MULTI};
  - a clog2 helper function.
- Sub-module keypad_col_scanner contains the dwell counter, column rotation, row synchroniser and snapshot register. It outputs snapshot[ROWS*COLS-1:0] and frame_end.
- The top level keypad_scanner holds the classifier and the FSM.

Test Plan:
All scenarios use ROWS = 4, COLS = 4, SCAN_DIV = 4 (frame = 16 clocks) and DEBOUNCE_FRAMES = 3 unless noted.
1. Reset and scan order: release rst with scan_en = 1 -> col_drv = 0001, 0010, 0100, 1000, 0001, each held 4 clocks; all outputs 0.
2. Clean press and release: hold row 2 closed only during col 1 for 5 frames, then open -> key_valid single pulse 1 clock after the 3rd frame end, key_code = 9, key_held = 1. Key_release pulse 1 clock after the 3rd empty frame end.
3. Bounce: key 9 present for 2 frames, absent 1, present 3 -> exactly one key_valid, after the final 3rd consecutive frame; no key_release.
4. Multi-key: keys 0 and 15 closed together from idle -> multi_key = 1, no key_valid. Press 5 and hold, then add key 6 -> key_held stays 1 and key_code stays 5.
5. Repeat: REPEAT_FRAMES = 2, hold key 3 for 10 frames after acceptance -> key_valid pulses at acceptance, then every 2 frames (6 pulses total), key_code = 3 each time.
6. Disable and reset: drop scan_en while key 9 is held -> col_drv = 0 and one key_release pulse. Assert rst mid-dwell -> all outputs 0 in the same cycle, with no pulses.
